cim_bus_responder: RTL and testbench

Memory-mapped compute-in-memory (CIM) responder on the core's data bus, decoded at CIM base address 0x08000000. It is the slave end of the load/store interface the core drives: it accepts stores into an input buffer and a weight buffer, and runs a signed int8 multiply-accumulate over them. It returns register and buffer contents on loads with zero wait states, and asserts HLT to stall the core while an access targets a busy engine.

---
 rtl/cim_pkg.sv | 24 ++
 rtl/cim_mac_engine.sv | 86 ++++++++
 rtl/cim_bus_responder.sv | 115 +++++++++++
 tb/tb_cim_bus_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared definitions for the CIM bus responder: address map, register bit
// positions and the MAC engine state type.
package cim_pkg;

    localparam logic [31:0] CIM_BASE_ADDR = 32'h0800_0000;

    localparam logic [9:0] OFF_CTRL   = 10'h000;
    localparam logic [9:0] OFF_STATUS = 10'h001;
    localparam logic [9:0] OFF_LEN    = 10'h002;
    localparam logic [9:0] OFF_RESULT = 10'h003;
    localparam logic [9:0] OFF_IN_BUF = 10'h100;
    localparam logic [9:0] OFF_W_BUF  = 10'h200;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ACC   = 1;
    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_DONE  = 1;

    typedef enum logic {
        IDLE,
        RUN
    } cim_state_e;

endpackage

// File: rtl/cim_mac_engine.sv
// Sequential signed int8 dot-product engine: one term per cycle, result
// accumulates modulo 2^32. Buffer bytes are supplied by the parent via eidx.
module cim_mac_engine
    import cim_pkg::*;
#(
    parameter int unsigned  DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          acc,
    input  logic [8:0]    len,
    output logic [AW-1:0] eidx,
    input  logic [7:0]    in_byte,
    input  logic [7:0]    w_byte,
    output logic          busy,
    output logic          done,
    output logic [31:0]   result
);

    cim_state_e    state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [8:0]    n_q, n_d;
    logic [31:0]   result_q, result_d;
    logic          done_q, done_d;

    logic [8:0]        n_eff;
    logic signed [15:0] prod;

    assign n_eff = (len > 9'(DEPTH)) ? 9'(DEPTH) : len;
    assign prod  = 16'($signed(in_byte)) * 16'($signed(w_byte));

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        result_d = result_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = 1'b0;
                    k_d    = '0;
                    n_d    = n_eff;
                    if (!acc) result_d = '0;
                    // A zero-length run skips RUN and reports done directly.
                    if (n_eff == 9'd0) done_d = 1'b1;
                    else               state_d = RUN;
                end
            end
            RUN: begin
                result_d = result_q + {{16{prod[15]}}, prod};
                if (9'(k_q) == n_q - 9'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign eidx   = k_q;
    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: rtl/cim_bus_responder.sv
// Memory-mapped CIM slave: address decode, control registers, input/weight
// buffers, zero-wait load mux and stall generation around the MAC engine.
module cim_bus_responder
    import cim_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter logic [31:0] BASE_WADDR = CIM_BASE_ADDR >> 2
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAI,
    input  logic [3:0]  BE,
    input  logic        WR,
    input  logic        RD,
    output logic [31:0] DATAO,
    output logic        HLT,
    output logic        IRQ_DONE
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned WW     = AW - 2;
    localparam logic [7:0]  NWORDS = 8'(DEPTH / 4);

    logic [31:0] in_mem_q [DEPTH/4];
    logic [31:0] w_mem_q  [DEPTH/4];

    logic [8:0]    len_q, len_d;
    logic          irq_q, irq_d;
    logic          hit, halt, wr_en, rd_en, start;
    logic          in_sel, w_sel;
    logic [9:0]    off;
    logic [WW-1:0] widx;
    logic [AW-1:0] eidx;
    logic [7:0]    in_byte, w_byte;
    logic          busy, done;
    logic [31:0]   result;
    logic [31:0]   rdata;

    assign hit    = (DADDR[31:10] == BASE_WADDR[31:10]);
    assign off    = DADDR[9:0];
    assign widx   = off[WW-1:0];
    assign in_sel = (off[9:8] == OFF_IN_BUF[9:8]) && (off[7:0] < NWORDS);
    assign w_sel  = (off[9:8] == OFF_W_BUF[9:8]) && (off[7:0] < NWORDS);

    // Status polling is the only access allowed through while the engine runs.
    assign halt  = busy && hit && (RD || WR) && (off != OFF_STATUS);
    assign wr_en = hit && WR && !halt;
    assign rd_en = hit && RD && !WR && !halt;
    assign start = wr_en && (off == OFF_CTRL) && DATAI[CTRL_START];
    assign HLT   = halt;

    assign in_byte = in_mem_q[eidx[AW-1:2]][{eidx[1:0], 3'b000} +: 8];
    assign w_byte  = w_mem_q[eidx[AW-1:2]][{eidx[1:0], 3'b000} +: 8];

    cim_mac_engine #(.DEPTH(DEPTH)) u_engine (
        .clk     (CLK),
        .rst     (RES),
        .start   (start),
        .acc     (DATAI[CTRL_ACC]),
        .len     (len_q),
        .eidx    (eidx),
        .in_byte (in_byte),
        .w_byte  (w_byte),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always_comb begin
        len_d = len_q;
        if (wr_en && (off == OFF_LEN)) len_d = DATAI[8:0];
        irq_d = done;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            len_q <= '0;
            irq_q <= 1'b0;
        end else begin
            len_q <= len_d;
            irq_q <= irq_d;
        end
    end

    // Buffers hold their contents across reset.
    always_ff @(posedge CLK) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (wr_en && in_sel && BE[b]) in_mem_q[widx][8*b +: 8] <= DATAI[8*b +: 8];
            if (wr_en && w_sel && BE[b])  w_mem_q[widx][8*b +: 8]  <= DATAI[8*b +: 8];
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (off == OFF_STATUS) begin
                rdata[STAT_BUSY] = busy;
                rdata[STAT_DONE] = done;
            end else if (off == OFF_LEN) begin
                rdata[8:0] = len_q;
            end else if (off == OFF_RESULT) begin
                rdata = result;
            end else if (in_sel) begin
                rdata = in_mem_q[widx];
            end else if (w_sel) begin
                rdata = w_mem_q[widx];
            end
        end
    end

    assign DATAO    = rdata;
    assign IRQ_DONE = irq_q;

endmodule

// File: tb/tb_cim_bus_responder.sv
// Scoreboard bench for cim_bus_responder: a transaction-level model predicts
// load data, stall lengths and the done interrupt.
module tb_cim_bus_responder;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0200_0000;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic [31:0] DADDR = '0;
    logic [31:0] DATAI = '0;
    logic [3:0]  BE = '0;
    logic        WR = 1'b0;
    logic        RD = 1'b0;
    logic [31:0] DATAO;
    logic        HLT;
    logic        IRQ_DONE;

    cim_bus_responder #(.DEPTH(DEPTH), .BASE_WADDR(BASE)) dut (
        .CLK      (CLK),
        .RES      (RES),
        .DADDR    (DADDR),
        .DATAI    (DATAI),
        .BE       (BE),
        .WR       (WR),
        .RD       (RD),
        .DATAO    (DATAO),
        .HLT      (HLT),
        .IRQ_DONE (IRQ_DONE)
    );

    always #5 CLK = ~CLK;

    longint cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    // Reference state: byte arrays, LEN, RESULT, and the cycle the current run
    // ends in (busy through run_end, done from run_end+1).
    byte    in_m[DEPTH];
    byte    w_m[DEPTH];
    int     m_len = 0;
    int     m_result = 0;
    longint run_end = -1;
    bit     done_flag = 0;

    function automatic logic [31:0] ra(int o);
        return BASE + 32'(o);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a, longint t);
        int o = int'(a[9:0]);
        int w;
        if (a[31:10] != BASE[31:10]) return 32'h0;
        if (o == 1) return {30'h0, done_flag && (t > run_end), t <= run_end};
        if (o == 2) return 32'(m_len);
        if (o == 3) return 32'(m_result);
        if (o >= 'h100 && o < 'h100 + DEPTH/4) begin
            w = o - 'h100;
            return {in_m[4*w+3], in_m[4*w+2], in_m[4*w+1], in_m[4*w]};
        end
        if (o >= 'h200 && o < 'h200 + DEPTH/4) begin
            w = o - 'h200;
            return {w_m[4*w+3], w_m[4*w+2], w_m[4*w+1], w_m[4*w]};
        end
        return 32'h0;
    endfunction

    task automatic model_write(logic [31:0] a, logic [31:0] d, logic [3:0] be, longint t);
        int o = int'(a[9:0]);
        int n;
        if (a[31:10] != BASE[31:10]) return;
        if (o == 0 && d[0]) begin
            n = (m_len > int'(DEPTH)) ? int'(DEPTH) : m_len;
            if (!d[1]) m_result = 0;
            for (int k = 0; k < n; k++) m_result += int'(in_m[k]) * int'(w_m[k]);
            run_end   = t + longint'(n);
            done_flag = 1;
        end else if (o == 2) begin
            m_len = int'(d[8:0]);
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be[b] && o >= 'h100 && o < 'h100 + DEPTH/4) in_m[4*(o-'h100)+b] = d[8*b +: 8];
                if (be[b] && o >= 'h200 && o < 'h200 + DEPTH/4) w_m[4*(o-'h200)+b]  = d[8*b +: 8];
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic bus(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        longint exp_stall;
        longint eff;
        longint stalls;
        bit hit;
        hit = (a[31:10] == BASE[31:10]);
        exp_stall = (hit && a[9:0] != 10'h001 && cyc <= run_end) ? run_end + 1 - cyc : 0;
        eff = cyc + exp_stall;
        if (wr) model_write(a, d, be, eff);
        else    sb.push_back(model_read(a, eff));
        WR = wr; RD = !wr; DADDR = a; DATAI = d; BE = be;
        stalls = 0;
        forever begin
            @(negedge CLK);
            if (!HLT) break;
            stalls++;
            if (stalls > 5000) begin
                errors++;
                $display("FAIL hlt_timeout addr=%h stalled %0d cycles", a, stalls);
                break;
            end
        end
        checks++;
        if (stalls != exp_stall) begin
            errors++;
            $display("FAIL stall_len addr=%h wr=%0b got %0d expected %0d", a, wr, stalls, exp_stall);
        end
        @(posedge CLK); #1;
        WR = 1'b0; RD = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic do_reset();
        RES = 1'b1; WR = 1'b0; RD = 1'b0;
        @(posedge CLK); #1;
        RES = 1'b0;
        m_result = 0; m_len = 0; done_flag = 0; run_end = -1;
    endtask

    task automatic check_irq();
        while (cyc < run_end + 2) idle(1);
        @(negedge CLK);
        checks++;
        if (IRQ_DONE !== done_flag) begin
            errors++;
            $display("FAIL irq_done got %b expected %b", IRQ_DONE, done_flag);
        end
        @(posedge CLK); #1;
    endtask

    always @(negedge CLK) begin
        if (!RES && RD && !WR && !HLT) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected addr=%h data=%h", DADDR, DATAO);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                checks++;
                if (DATAO !== exp) begin
                    errors++;
                    $display("FAIL read_data addr=%h got %h expected %h", DADDR, DATAO, exp);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin in_m[i] = 0; w_m[i] = 0; end
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // Reset state
        bus(0, ra(1), '0, '0);
        bus(0, ra(2), '0, '0);
        bus(0, ra(3), '0, '0);
        check_irq();

        for (int w = 0; w < int'(DEPTH/4); w++) begin
            bus(1, ra('h100 + w), $urandom, 4'hF);
            bus(1, ra('h200 + w), $urandom, 4'hF);
        end

        // Basic dot product, busy window polled every cycle
        bus(1, ra('h100), 32'h0403_0201, 4'hF);
        bus(1, ra('h200), 32'h0807_0605, 4'hF);
        bus(1, ra(2), 32'd4, 4'hF);
        bus(1, ra(0), 32'h1, 4'hF);
        repeat (6) bus(0, ra(1), '0, '0);
        bus(0, ra(3), '0, '0);
        check_irq();

        // Signed extremes, then accumulate one more term
        bus(1, ra('h100), 32'h8080_8080, 4'hF);
        bus(1, ra('h200), 32'h8080_8080, 4'hF);
        bus(1, ra(0), 32'h1, 4'hF);
        bus(0, ra(3), '0, '0);
        bus(1, ra('h100), 32'h0000_007F, 4'b0001);
        bus(1, ra('h200), 32'h0000_0080, 4'b0001);
        bus(1, ra(2), 32'd1, 4'hF);
        bus(1, ra(0), 32'h3, 4'hF);
        bus(0, ra(3), '0, '0);
        bus(0, ra('h100), '0, '0);

        // Full-depth run with stalled START and stalled weight store
        bus(1, ra(2), 32'd64, 4'hF);
        bus(1, ra(0), 32'h1, 4'hF);
        bus(0, ra(1), '0, '0);
        bus(0, ra(1), '0, '0);
        bus(1, ra(0), 32'h1, 4'hF);
        bus(0, ra(1), '0, '0);
        bus(1, ra('h200), 32'hDEAD_BEEF, 4'hF);
        bus(0, ra('h200), '0, '0);
        bus(0, ra(3), '0, '0);
        check_irq();

        // Zero length, with and without ACC
        bus(1, ra(2), 32'd0, 4'hF);
        bus(1, ra(0), 32'h3, 4'hF);
        bus(0, ra(1), '0, '0);
        bus(0, ra(3), '0, '0);
        bus(1, ra(0), 32'h1, 4'hF);
        bus(0, ra(1), '0, '0);
        bus(0, ra(3), '0, '0);

        // Length clamp: a stalled RESULT read measures the run length
        bus(1, ra(2), 32'd300, 4'hF);
        bus(0, ra(2), '0, '0);
        bus(1, ra(0), 32'h1, 4'hF);
        bus(0, ra(3), '0, '0);

        // Byte enables
        bus(1, ra('h105), 32'hAABB_CCDD, 4'hF);
        bus(1, ra('h105), 32'h1122_3344, 4'b0100);
        bus(0, ra('h105), '0, '0);

        // Reset mid-run; buffers survive
        bus(1, ra(2), 32'd8, 4'hF);
        bus(1, ra(0), 32'h1, 4'hF);
        idle(2);
        do_reset();
        bus(0, ra(1), '0, '0);
        bus(0, ra(3), '0, '0);
        bus(0, ra(2), '0, '0);
        bus(0, ra('h100), '0, '0);
        bus(0, ra('h105), '0, '0);
        bus(0, ra('h200), '0, '0);
        check_irq();

        // Decode boundaries
        bus(0, ra('h3FF), '0, '0);
        bus(0, 32'h01FF_FFFF, '0, '0);
        bus(1, 32'h01FF_FC00, 32'h1, 4'hF);
        bus(1, 32'h01FF_FC02, 32'd5, 4'hF);
        bus(1, ra('h110), 32'hFFFF_FFFF, 4'hF);
        bus(1, ra('h3FF), 32'hFFFF_FFFF, 4'hF);
        bus(0, ra(1), '0, '0);
        bus(0, ra(2), '0, '0);
        bus(0, ra('h110), '0, '0);
        bus(0, ra('h20F), '0, '0);

        // Randomized runs
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) begin
                int w;
                w = $urandom_range(0, DEPTH/4 - 1);
                bus(1, ra(($urandom_range(0, 1) ? 'h200 : 'h100) + w), $urandom, 4'($urandom));
            end
            bus(1, ra(2), 32'($urandom_range(0, 70)), 4'hF);
            bus(1, ra(0), {30'h0, 1'($urandom), 1'b1}, 4'hF);
            repeat ($urandom_range(0, 5)) bus(0, ra(1), '0, '0);
            if ($urandom_range(0, 1) == 1) bus(0, ra('h100 + $urandom_range(0, DEPTH/4 - 1)), '0, '0);
            bus(0, ra(3), '0, '0);
        end
        check_irq();

        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected reads", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
